// File: rtl/mem_access_unit.sv
// Memory access sequencer: holds MAR/MDR and drives active-low SRAM strobes
// for a fixed number of wait cycles per read or write, then pulses Ready.
module mem_access_unit #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] Bus,
    input  logic        LD_MAR,
    input  logic        LD_MDR,
    input  logic        Start_R,
    input  logic        Start_W,
    input  logic [15:0] Data_from_SRAM,
    output logic [15:0] MAR,
    output logic [15:0] MDR,
    output logic [15:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    output logic        CE_n,
    output logic        OE_n,
    output logic        WE_n,
    output logic        Busy,
    output logic        Ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mar_q   <= 16'h0000;
            mdr_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    // Registers only accept bus loads in IDLE so the address and write data
    // stay frozen for the whole access; requests while busy are dropped.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        case (state_q)
            IDLE: begin
                if (LD_MAR) mar_d = Bus;
                if (LD_MDR) mdr_d = Bus;
                if (Start_R) begin
                    state_d = READ;
                    cnt_d   = CNT_INIT;
                end else if (Start_W) begin
                    state_d = WRITE;
                    cnt_d   = CNT_INIT;
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    mdr_d   = Data_from_SRAM;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Strobes decode from the state register alone: no input reaches them combinationally.
    assign CE_n         = ~((state_q == READ) || (state_q == WRITE));
    assign OE_n         = ~(state_q == READ);
    assign WE_n         = ~(state_q == WRITE);
    assign Ready        = (state_q == DONE);
    assign Busy         = (state_q != IDLE);
    assign MAR          = mar_q;
    assign MDR          = mdr_q;
    assign ADDR         = mar_q;
    assign Data_to_SRAM = (state_q == WRITE) ? mdr_q : 16'h0000;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: instances with WAIT_CYCLES 2, 1 and 15
// share one stimulus set; index 0 is the WAIT_CYCLES=2 unit.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus;
    logic        ld_mar, ld_mdr, start_r, start_w;
    logic [15:0] din;

    logic [15:0] mar [3];
    logic [15:0] mdr [3];
    logic [15:0] addr [3];
    logic [15:0] dts [3];
    logic        ce [3];
    logic        oe [3];
    logic        we [3];
    logic        busy [3];
    logic        rdy [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.WAIT_CYCLES(2)) u_w2 (
        .Clk(clk), .Reset(rst), .Bus(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
        .Start_R(start_r), .Start_W(start_w), .Data_from_SRAM(din),
        .MAR(mar[0]), .MDR(mdr[0]), .ADDR(addr[0]), .Data_to_SRAM(dts[0]),
        .CE_n(ce[0]), .OE_n(oe[0]), .WE_n(we[0]), .Busy(busy[0]), .Ready(rdy[0])
    );

    mem_access_unit #(.WAIT_CYCLES(1)) u_w1 (
        .Clk(clk), .Reset(rst), .Bus(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
        .Start_R(start_r), .Start_W(start_w), .Data_from_SRAM(din),
        .MAR(mar[1]), .MDR(mdr[1]), .ADDR(addr[1]), .Data_to_SRAM(dts[1]),
        .CE_n(ce[1]), .OE_n(oe[1]), .WE_n(we[1]), .Busy(busy[1]), .Ready(rdy[1])
    );

    mem_access_unit #(.WAIT_CYCLES(15)) u_w15 (
        .Clk(clk), .Reset(rst), .Bus(bus), .LD_MAR(ld_mar), .LD_MDR(ld_mdr),
        .Start_R(start_r), .Start_W(start_w), .Data_from_SRAM(din),
        .MAR(mar[2]), .MDR(mdr[2]), .ADDR(addr[2]), .Data_to_SRAM(dts[2]),
        .CE_n(ce[2]), .OE_n(oe[2]), .WE_n(we[2]), .Busy(busy[2]), .Ready(rdy[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starting in the first strobe cycle of unit 0, run until strobes release.
    task automatic run_access(output int width, output int oe_lo, output int we_lo);
        width = 0; oe_lo = 0; we_lo = 0;
        while (ce[0] == 1'b0 && width < 40) begin
            width++;
            if (oe[0] == 1'b0) oe_lo++;
            if (we[0] == 1'b0) we_lo++;
            tick();
        end
    endtask

    initial begin
        int w, ol, wl, rdy_cnt;
        int ce_cnt [3];
        int rdy_at [3];
        int first_ce [3];

        rst = 1'b1; bus = 16'h0; ld_mar = 1'b0; ld_mdr = 1'b0;
        start_r = 1'b0; start_w = 1'b0; din = 16'h0;
        tick();
        rst = 1'b0;
        chk("rst_ce", ce[0], 1);
        chk("rst_oe", oe[0], 1);
        chk("rst_we", we[0], 1);
        chk("rst_busy", busy[0], 0);
        chk("rst_ready", rdy[0], 0);
        chk("rst_mar", mar[0], 16'h0000);
        chk("rst_mdr", mdr[0], 16'h0000);
        chk("rst_dts", dts[0], 16'h0000);

        // Read of 0x3000 returning 0xBEEF
        bus = 16'h3000; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0; start_r = 1'b1; din = 16'hBEEF;
        tick();
        start_r = 1'b0;
        chk("rd_oe_first", oe[0], 0);
        chk("rd_we_first", we[0], 1);
        chk("rd_addr", addr[0], 16'h3000);
        chk("rd_busy", busy[0], 1);
        chk("rd_ready_early", rdy[0], 0);
        run_access(w, ol, wl);
        chk("rd_width", w, 2);
        chk("rd_oe_cycles", ol, 2);
        chk("rd_we_cycles", wl, 0);
        chk("rd_ready", rdy[0], 1);
        chk("rd_busy_done", busy[0], 1);
        chk("rd_mdr", mdr[0], 16'hBEEF);
        tick();
        chk("rd_ready_off", rdy[0], 0);
        chk("rd_idle", busy[0], 0);

        // Write 0x1234 to 0x4001
        bus = 16'h4001; ld_mar = 1'b1;
        tick();
        bus = 16'h1234; ld_mar = 1'b0; ld_mdr = 1'b1;
        tick();
        ld_mdr = 1'b0; start_w = 1'b1; bus = 16'h0000;
        chk("wr_dts_idle", dts[0], 16'h0000);
        tick();
        start_w = 1'b0;
        chk("wr_we_first", we[0], 0);
        chk("wr_dts", dts[0], 16'h1234);
        chk("wr_addr", addr[0], 16'h4001);
        run_access(w, ol, wl);
        chk("wr_width", w, 2);
        chk("wr_we_cycles", wl, 2);
        chk("wr_oe_cycles", ol, 0);
        chk("wr_ready", rdy[0], 1);
        chk("wr_dts_done", dts[0], 16'h0000);
        chk("wr_mdr", mdr[0], 16'h1234);
        tick();

        // Simultaneous Start_R and Start_W: read wins
        din = 16'h5A5A; start_r = 1'b1; start_w = 1'b1;
        tick();
        start_r = 1'b0; start_w = 1'b0;
        run_access(w, ol, wl);
        chk("both_oe_cycles", ol, 2);
        chk("both_we_cycles", wl, 0);
        chk("both_mdr", mdr[0], 16'h5A5A);
        tick();

        // Same-edge load and write: new MAR/MDR used from the first strobe cycle
        bus = 16'hABCD; ld_mar = 1'b1; ld_mdr = 1'b1; start_w = 1'b1;
        tick();
        ld_mar = 1'b0; ld_mdr = 1'b0; start_w = 1'b0; bus = 16'h0000;
        chk("same_addr", addr[0], 16'hABCD);
        chk("same_dts", dts[0], 16'hABCD);
        run_access(w, ol, wl);
        tick();

        // Loads and requests during an active read are ignored
        bus = 16'h3000; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0; start_r = 1'b1; din = 16'hC0DE;
        tick();
        bus = 16'hFFFF; ld_mar = 1'b1; ld_mdr = 1'b1;
        rdy_cnt = 0; w = 0;
        for (int k = 0; k < 10; k++) begin
            if (ce[0] == 1'b0) w++;
            if (rdy[0]) begin
                rdy_cnt++;
                start_r = 1'b0; ld_mar = 1'b0; ld_mdr = 1'b0;
            end
            tick();
        end
        chk("busy_mar", mar[0], 16'h3000);
        chk("busy_addr", addr[0], 16'h3000);
        chk("busy_mdr", mdr[0], 16'hC0DE);
        chk("busy_width", w, 2);
        chk("busy_ready_pulses", rdy_cnt, 1);

        // Reset in the second read cycle aborts the access
        bus = 16'h7777; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0; start_r = 1'b1; din = 16'h9999;
        tick();
        start_r = 1'b0;
        tick();
        chk("abort_in_read", oe[0], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ce", ce[0], 1);
        chk("abort_oe", oe[0], 1);
        chk("abort_mar", mar[0], 16'h0000);
        chk("abort_mdr", mdr[0], 16'h0000);
        rdy_cnt = 0;
        for (int k = 0; k < 5; k++) begin
            if (rdy[0]) rdy_cnt++;
            tick();
        end
        chk("abort_no_ready", rdy_cnt, 0);

        // Strobe width and Ready timing for WAIT_CYCLES 2, 1, 15
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ce_cnt[i] = 0; rdy_at[i] = 0; first_ce[i] = 0;
        end
        for (int k = 1; k <= 40; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (ce[i] == 1'b0) begin
                    ce_cnt[i]++;
                    if (first_ce[i] == 0) first_ce[i] = k;
                end
                if (rdy[i] && rdy_at[i] == 0) rdy_at[i] = k;
            end
            tick();
        end
        chk("w2_width", ce_cnt[0], 2);
        chk("w1_width", ce_cnt[1], 1);
        chk("w15_width", ce_cnt[2], 15);
        chk("w2_first", first_ce[0], 1);
        chk("w1_first", first_ce[1], 1);
        chk("w15_first", first_ce[2], 1);
        chk("w2_ready_at", rdy_at[0], 3);
        chk("w1_ready_at", rdy_at[1], 2);
        chk("w15_ready_at", rdy_at[2], 16);
        chk("w15_idle_end", busy[2], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, memory access length in clock cycles; legal range 1..15.
REQ-002 Clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-004 Bus  input  16  shared datapath bus value (tri-state bus-mux output).
REQ-005 LD_MAR  input  1  load MAR from Bus.
REQ-006 LD_MDR  input  1  load MDR from Bus.
REQ-007 Start_R  input  1  request memory read at address MAR.
REQ-008 Start_W  input  1  request memory write of MDR to address MAR.
REQ-009 Data_from_SRAM  input  16  memory read data.
REQ-010 MAR  output  16  memory address register.
REQ-011 MDR  output  16  memory data register; drives the MDR input of the bus mux.
REQ-012 ADDR  output  16  memory address; always equals MAR.
REQ-013 Data_to_SRAM  output  16  write data; MDR while WE_n=0, else 16'h0000.
REQ-014 CE_n, OE_n, WE_n  output  1 each  active-low memory chip enable, output enable, write enable.
REQ-015 Busy  output  1  high in any state other than IDLE.
REQ-016 Ready  output  1  one-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, READ, WRITE, DONE; 4-bit down-counter CNT.
REQ-018 IDLE: CE_n=OE_n=WE_n=1, Ready=0, Busy=0.
REQ-019 IDLE, Start_R=1 -> READ, CNT<=WAIT_CYCLES-1; Start_R has priority when Start_R and Start_W are both high.
REQ-020 IDLE, Start_W=1, Start_R=0 -> WRITE, CNT<=WAIT_CYCLES-1.
REQ-021 READ: CE_n=0, OE_n=0, WE_n=1; CNT decrements each cycle; at CNT=0, MDR<=Data_from_SRAM on that edge, then -> DONE.
REQ-022 WRITE: CE_n=0, WE_n=0, OE_n=1, Data_to_SRAM=MDR; CNT decrements each cycle; at CNT=0 -> DONE; MDR unchanged.
REQ-023 DONE: strobes deasserted, Ready=1, Busy=1 for exactly one cycle, then -> IDLE unconditionally.
REQ-024 Latency: request sampled at edge t -> strobes active for exactly WAIT_CYCLES cycles starting at cycle t+1; Ready high in cycle t+WAIT_CYCLES+1; next request accepted at edge ending that Ready cycle +1 (first IDLE cycle).
REQ-025 LD_MAR=1 in IDLE -> MAR<=Bus; ignored in READ/WRITE/DONE so ADDR is stable for the whole access.
REQ-026 LD_MDR=1 in IDLE -> MDR<=Bus; ignored in READ/WRITE/DONE.
REQ-027 Same-edge LD_MAR and Start_R/Start_W in IDLE: the access uses the newly loaded MAR value (same for LD_MDR with Start_W); ADDR/Data_to_SRAM present new value from cycle t+1.
REQ-028 Start_R/Start_W asserted while Busy=1 are ignored, not queued.
REQ-029 Strobe outputs are registered or decoded from state only; no combinational path from any input to CE_n/OE_n/WE_n/Ready.
REQ-030 No illegal-state lockup: any unreachable state encoding returns to IDLE next edge.

Reset
REQ-031 Reset=1 at a rising edge: state<=IDLE, CNT<=0, MAR<=16'h0000, MDR<=16'h0000; outputs then CE_n=OE_n=WE_n=1, Ready=0, Busy=0.
REQ-032 Reset has priority over all loads and requests on the same edge.
REQ-033 Reset mid-READ/WRITE aborts the access: strobes deassert in the cycle after the edge, MDR is not loaded from memory, no Ready pulse is produced.

Verification
REQ-034 Read, WAIT_CYCLES=2: Bus=16'h3000 with LD_MAR, then Start_R, memory returns 16'hBEEF -> OE_n/CE_n low exactly 2 cycles, ADDR=16'h3000, MDR=16'hBEEF, Ready one cycle later.
REQ-035 Write: LD_MAR with Bus=16'h4001, LD_MDR with Bus=16'h1234, Start_W -> WE_n low 2 cycles, Data_to_SRAM=16'h1234 only while WE_n=0, OE_n stays 1, MDR unchanged.
REQ-036 Simultaneous Start_R and Start_W in IDLE -> read performed, WE_n never asserted.
REQ-037 LD_MAR with Bus=16'hFFFF and Start_R issued during an active read -> MAR and ADDR unchanged, no second access, single Ready pulse.
REQ-038 Reset asserted in second READ cycle -> strobes high next cycle, MAR=MDR=16'h0000, Ready never pulses.
REQ-039 WAIT_CYCLES=1 and WAIT_CYCLES=15 -> strobe width 1 and 15 cycles respectively, Ready timing per REQ-024.
